// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage program-counter sequencer and the exception unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PCS_BOOT  = 2'd0,
    PCS_RUN   = 2'd1,
    PCS_FLUSH = 2'd2
  } pc_state_e;

  // The exception unit uses these same vectors, so they live here rather than in the top.
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority selection of next pc, next state, epc load and misalign.
// Optional feature: PC_ALIGN_CHECK_EN turns misaligned redirect targets into exceptions.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(PC_EXC_VEC)
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter int              STEP    = 4
`endif
) (
  input  pc_state_e         state,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   pc_seq,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_target,
  input  logic              exc_req,
  output logic [PC_W-1:0]   pc_next,
  output pc_state_e         state_next,
  output logic              epc_load,
  output logic [PC_W-1:0]   epc_next,
  output logic              misalign_next
);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
  logic bad_target;
  assign bad_target = |(redirect_target & ALIGN_MASK);
`endif

  always_comb begin
    pc_next       = pc;
    state_next    = state;
    epc_load      = 1'b0;
    epc_next      = pc;
    misalign_next = 1'b0;
    unique case (state)
      PCS_BOOT: state_next = PCS_RUN;
      PCS_RUN, PCS_FLUSH: begin
        // RUN and FLUSH share the redirect priority; only the fall-through differs.
        if (exc_req) begin
          pc_next    = EXC_VEC;
          epc_load   = 1'b1;
          state_next = PCS_FLUSH;
        end else if (redirect) begin
          pc_next    = redirect_target;
          state_next = PCS_FLUSH;
`ifdef PC_ALIGN_CHECK_EN
          if (bad_target) begin
            pc_next       = EXC_VEC;
            epc_load      = 1'b1;
            epc_next      = redirect_target;
            misalign_next = 1'b1;
          end
`endif
        end else if (state == PCS_RUN) begin
          if (!stall) pc_next = pc_seq;
        end else begin
          state_next = PCS_RUN;
        end
      end
      default: state_next = PCS_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program-counter sequencer: state, pc, epc and misalign registers.
// Optional feature: PC_ALIGN_CHECK_EN enables the redirect target alignment check.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(PC_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(PC_EXC_VEC),
  parameter int              STEP      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            exc_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_seq,
  output logic            pc_valid,
  output logic [PC_W-1:0] epc,
  output logic            misalign
);

  localparam logic [PC_W-1:0] STEP_INC = PC_W'(STEP);

  pc_state_e       state, state_next;
  logic [PC_W-1:0] pc_next, epc_next;
  logic            epc_load, misalign_next;

  assign pc_seq   = pc + STEP_INC;
  assign pc_valid = (state == PCS_RUN);

  pc_next_sel #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .STEP    (STEP)
`endif
  ) u_next_sel (
    .state           (state),
    .pc              (pc),
    .pc_seq          (pc_seq),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .pc_next         (pc_next),
    .state_next      (state_next),
    .epc_load        (epc_load),
    .epc_next        (epc_next),
    .misalign_next   (misalign_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= PCS_BOOT;
      pc       <= RESET_VEC;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      misalign <= misalign_next;
      if (epc_load) epc <= epc_next;
    end
  end

endmodule
